pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning number of PWM channels (1..8).
REQ-002 SHALL have parameter CW, default 8, meaning counter/period/duty and data bus width (8..16).
REQ-003 SHALL have parameter DEF_PERIOD, default 200, meaning reset value of every PERIOD register.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd  input  1  register read strobe, one cycle.
REQ-007 SHALL have port wr  input  1  register write strobe, one cycle.
REQ-008 SHALL have port adrs  input  8  byte address.
REQ-009 SHALL have port din  input  CW  write data.
REQ-010 SHALL have port dout  output  CW  registered read data.
REQ-011 SHALL have port pwmo  output  NCH  PWM outputs, bit n = channel n.
REQ-012 SHALL have port irq  output  1  registered interrupt, active-high.

Function
REQ-013 SHALL map channel n at base 16*n: +0x0 CTRL (bit0 EN, bit1 POL), +0x4 PERIOD, +0x8 DUTY, +0xC reserved (reads 0, writes ignored).
REQ-014 SHALL map global STATUS at 0xF0 (bit n = channel n wrap flag, W1C) and IRQ_MASK at 0xF4 (RW).
REQ-015 SHALL ignore writes and return 0 on reads to unmapped addresses and channels >= NCH.
REQ-016 SHALL update dout on the clock edge where rd=1 (latency 1 cycle) and hold it otherwise.
REQ-017 SHALL return the pre-write value when rd and wr hit the same address in the same cycle.
REQ-018 SHALL store PERIOD/DUTY writes in pending registers; reads return pending values.
REQ-019 SHALL copy pending PERIOD/DUTY into active registers when EN=0, or when EN=1 and cnt == active PERIOD (wrap cycle).
REQ-020 SHALL, when EN=1, count cnt 0..PERIOD then wrap to 0, giving a period of PERIOD+1 clocks.
REQ-021 SHALL drive raw output high when cnt < active DUTY; DUTY=0 gives constant low, DUTY > PERIOD gives constant high.
REQ-022 SHALL hold cnt at 0 when EN=0 and drive raw output low.
REQ-023 SHALL, on EN 0->1, start counting from cnt=0 on the next cycle with the values loaded per REQ-019.
REQ-024 SHALL, with PERIOD=0, keep cnt at 0 and treat every enabled cycle as a wrap cycle.
REQ-025 SHALL register pwmo = raw XOR POL (one cycle after cnt), so the idle level equals POL.
REQ-026 SHALL set STATUS bit n on each wrap cycle of enabled channel n; set SHALL win over simultaneous W1C.
REQ-027 SHALL drive irq = |(STATUS & IRQ_MASK), registered.

Reset
REQ-028 SHALL, on rst low, asynchronously clear cnt, EN, POL, DUTY (pending and active), STATUS, IRQ_MASK, dout, pwmo, irq.
REQ-029 SHALL reset pending and active PERIOD to DEF_PERIOD.
REQ-030 SHALL resume from cnt=0 on the first rising clk after rst deasserts, regardless of mid-period reset.

Configuration
REQ-031 SHALL honour macro PWM_IRQ_EN: defined -> STATUS, IRQ_MASK and irq as specified.
REQ-032 SHALL, without PWM_IRQ_EN, omit STATUS/IRQ_MASK logic (reads 0, writes ignored) and tie irq to 0; the port remains.

Structure
REQ-033 SHALL place register offsets, CTRL bit indices and global addresses in shared package pwm_pkg.
REQ-034 SHALL implement one channel (cnt, pending/active registers, output) as sub-module pwm_channel, instantiated NCH times via generate.

Verification
REQ-035 SHALL check reset: after rst pulse, read PERIOD ch0 -> 200, DUTY -> 0, pwmo = 0, irq = 0.
REQ-036 SHALL check duty: ch1 PERIOD=9, DUTY=3, EN=1 -> pwmo[1] high 3 of every 10 clocks; POL=1 -> high 7 of 10.
REQ-037 SHALL check shadowing: ch0 PERIOD=9 DUTY=5 running, write DUTY=8 at cnt=2 -> current period high 5, next period high 8.
REQ-038 SHALL check boundaries: DUTY=0 -> constant low; DUTY=10 with PERIOD=9 -> constant high; PERIOD=0 DUTY=1 -> constant high, STATUS bit set every cycle.
REQ-039 SHALL check IRQ: IRQ_MASK=0x04, ch2 PERIOD=4 -> irq rises 2 cycles after wrap; W1C 0x04 coinciding with wrap leaves bit set.
REQ-040 SHALL check reset mid-period: assert rst at cnt=5 -> pwmo=0 immediately, cnt restarts at 0, EN=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared register map, CTRL bit positions and the offset decoder
// used by the PWM bank and its channels.
package pwm_pkg;

  // Per-channel register offsets inside a 16-byte channel window
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PERIOD = 4'h4;
  localparam logic [3:0] OFF_DUTY   = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  // CTRL bit indices
  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;

  // Global registers live in the top page
  localparam logic [7:0] ADR_STATUS   = 8'hF0;
  localparam logic [7:0] ADR_IRQ_MASK = 8'hF4;

  typedef enum logic [1:0] {
    SEL_CTRL,
    SEL_PERIOD,
    SEL_DUTY,
    SEL_NONE
  } reg_sel_e;

  // Map the low address nibble to a channel register; anything else is a hole
  function automatic reg_sel_e decode_off(input logic [3:0] off);
    reg_sel_e sel;
    case (off)
      OFF_CTRL:   sel = SEL_CTRL;
      OFF_PERIOD: sel = SEL_PERIOD;
      OFF_DUTY:   sel = SEL_DUTY;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel -- CTRL, pending/active PERIOD and DUTY,
// free-running counter and the registered, polarity-adjusted output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CW         = 8,
  parameter int DEF_PERIOD = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_ctrl,
  input  logic          i_wr_period,
  input  logic          i_wr_duty,
  input  logic [CW-1:0] i_wdata,
  output logic          o_en,
  output logic          o_pol,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_duty,
  output logic          o_wrap,
  output logic          o_pwm
);

  localparam logic [CW-1:0] RST_PERIOD = CW'(DEF_PERIOD);

  logic          r_en, r_pol, r_pwm;
  logic [CW-1:0] r_per_pend, r_duty_pend;
  logic [CW-1:0] r_per_act, r_duty_act;
  logic [CW-1:0] r_cnt;
  logic          w_wrap, w_load, w_raw;

  // A disabled channel tracks its pending values every cycle so that the
  // first enabled cycle already runs with them; an enabled one only swaps
  // at the wrap so a period is never cut short or mixed.
  assign w_wrap = r_en && (r_cnt == r_per_act);
  assign w_load = !r_en || w_wrap;
  assign w_raw  = r_en && (r_cnt < r_duty_act);

  // CTRL register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en  <= 1'b0;
      r_pol <= 1'b0;
    end else if (i_wr_ctrl) begin
      r_en  <= i_wdata[CTRL_EN];
      r_pol <= i_wdata[CTRL_POL];
    end
  end

  // Pending (software-visible) PERIOD/DUTY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per_pend  <= RST_PERIOD;
      r_duty_pend <= '0;
    end else begin
      if (i_wr_period) r_per_pend  <= i_wdata;
      if (i_wr_duty)   r_duty_pend <= i_wdata;
    end
  end

  // Active PERIOD/DUTY, shadow-loaded from the pending copies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per_act  <= RST_PERIOD;
      r_duty_act <= '0;
    end else if (w_load) begin
      r_per_act  <= r_per_pend;
      r_duty_act <= r_duty_pend;
    end
  end

  // Counter: held at 0 while disabled, 0..PERIOD while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (w_load)         r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  // Registered output; idle level equals POL because raw is low when disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pwm <= 1'b0;
    else      r_pwm <= w_raw ^ r_pol;
  end

  assign o_en     = r_en;
  assign o_pol    = r_pol;
  assign o_period = r_per_pend;
  assign o_duty   = r_duty_pend;
  assign o_wrap   = w_wrap;
  assign o_pwm    = r_pwm;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: NCH PWM channels behind a byte-addressed register bus with
// registered read data. Optional wrap-status/interrupt block is built only
// when PWM_IRQ_EN is defined; otherwise STATUS/IRQ_MASK read 0 and irq is 0.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int CW         = 8,
  parameter int DEF_PERIOD = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd,
  input  logic           wr,
  input  logic [7:0]     adrs,
  input  logic [CW-1:0]  din,
  output logic [CW-1:0]  dout,
  output logic [NCH-1:0] pwmo,
  output logic           irq
);

  reg_sel_e                 w_sel;
  logic [NCH-1:0]           w_hit;
  logic [NCH-1:0]           w_en, w_pol, w_wrap, w_pwm;
  logic [NCH-1:0][CW-1:0]   w_per, w_duty;
  logic [NCH-1:0]           w_status, w_mask;
  logic [CW-1:0]            w_rdata;
  logic [CW-1:0]            r_dout;

  assign w_sel = decode_off(adrs[3:0]);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign w_hit[n] = (adrs[7:4] == 4'(n));

    pwm_channel #(
      .CW         (CW),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_wr_ctrl   (wr && w_hit[n] && (w_sel == SEL_CTRL)),
      .i_wr_period (wr && w_hit[n] && (w_sel == SEL_PERIOD)),
      .i_wr_duty   (wr && w_hit[n] && (w_sel == SEL_DUTY)),
      .i_wdata     (din),
      .o_en        (w_en[n]),
      .o_pol       (w_pol[n]),
      .o_period    (w_per[n]),
      .o_duty      (w_duty[n]),
      .o_wrap      (w_wrap[n]),
      .o_pwm       (w_pwm[n])
    );
  end

`ifdef PWM_IRQ_EN
  logic [NCH-1:0] r_status, r_mask, w_clr;
  logic           r_irq;

  assign w_clr = (wr && (adrs == ADR_STATUS)) ? din[NCH-1:0] : '0;

  // Wrap flags: W1C, but a wrap in the same cycle keeps the bit set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_status <= '0;
    else      r_status <= (r_status & ~w_clr) | w_wrap;
  end

  // Interrupt mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_mask <= '0;
    else if (wr && (adrs == ADR_IRQ_MASK)) r_mask <= din[NCH-1:0];
  end

  // Registered interrupt from the already-registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= |(r_status & r_mask);
  end

  assign w_status = r_status;
  assign w_mask   = r_mask;
  assign irq      = r_irq;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = |w_wrap;
  assign w_status      = '0;
  assign w_mask        = '0;
  assign irq           = 1'b0;
`endif

  // Read mux; sees pre-write register values, so rd+wr to one address
  // returns the old contents
  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < NCH; n++) begin
      if (w_hit[n]) begin
        case (w_sel)
          SEL_CTRL: begin
            w_rdata[CTRL_EN]  = w_en[n];
            w_rdata[CTRL_POL] = w_pol[n];
          end
          SEL_PERIOD: w_rdata = w_per[n];
          SEL_DUTY:   w_rdata = w_duty[n];
          default:    w_rdata = '0;
        endcase
      end
    end
    if (adrs == ADR_STATUS)   w_rdata = CW'(w_status);
    if (adrs == ADR_IRQ_MASK) w_rdata = CW'(w_mask);
  end

  // Read data register, held between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_dout <= '0;
    else if (rd) r_dout <= w_rdata;
  end

  assign dout = r_dout;
  assign pwmo = w_pwm;

endmodule
